// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage. Owns the F-stage program counter and the F/D
//   pipeline register. Each cycle the PC takes the next PC from the next-PC
//   logic, or is redirected to the exception handler (req) or to the return
//   address (eret). A stall holds both the PC and the F/D register.
//
// Optional feature macro: FETCH_ADEL_CHECK_EN
//   Defined   : fetches that are misaligned or outside [IM_LO, IM_HI]
//               produce a bubble instruction (0) with exccode 4 (AdEL).
//   Undefined : no address check; fetched word is always im_rdata and
//               d_exccode is constant 0.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   npc[31:0]  in   next PC from the next-PC logic (taken verbatim)
//   stall      in   hazard stall: hold PC and F/D register
//   req        in   exception/interrupt taken this cycle (overrides stall)
//   eret       in   eret resolved in D (ignored while stalled)
//   epc[31:0]  in   return address for eret
//   d_is_jump  in   instruction in D is a branch/jump (fetch is a delay slot)
//   im_rdata   in   combinational instruction memory data at f_pc
//   f_pc       out  current fetch address
//   d_pc       out  PC of the instruction in D
//   d_instr    out  instruction in D
//   d_exccode  out  fetch exception code carried to D (0 none, 4 AdEL)
//   d_bd       out  D instruction is in a branch delay slot

module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        d_is_jump,
  input  logic [31:0] im_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr,
  output logic [4:0]  d_exccode,
  output logic        d_bd
);

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IM_LO     = 32'h0000_3000;
  localparam logic [31:0] IM_HI     = 32'h0000_6ffc;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;

  logic [31:0] f_pc_reg, f_pc_next;
  logic [31:0] d_pc_reg, d_pc_next;
  logic [31:0] d_instr_reg, d_instr_next;
  logic [4:0]  d_exccode_reg, d_exccode_next;
  logic        d_bd_reg, d_bd_next;

  logic [31:0] fetch_word;
  logic [4:0]  fetch_code;

`ifdef FETCH_ADEL_CHECK_EN
  logic fetch_illegal;

  always_comb begin
    fetch_illegal = (f_pc_reg[1:0] != 2'b00) || (f_pc_reg < IM_LO) || (f_pc_reg > IM_HI);
    fetch_word    = fetch_illegal ? 32'h0 : im_rdata;
    fetch_code    = fetch_illegal ? EXC_ADEL : 5'd0;
  end
`else
  always_comb begin
    fetch_word = im_rdata;
    fetch_code = 5'd0;
  end
`endif

  // Redirects (req, eret) flush F/D to a bubble carrying the target PC, so the
  // D stage sees a well-defined PC even though no instruction is present.
  always_comb begin
    f_pc_next      = f_pc_reg;
    d_pc_next      = d_pc_reg;
    d_instr_next   = d_instr_reg;
    d_exccode_next = d_exccode_reg;
    d_bd_next      = d_bd_reg;
    if (req) begin
      f_pc_next      = EXC_ENTRY;
      d_pc_next      = EXC_ENTRY;
      d_instr_next   = 32'h0;
      d_exccode_next = 5'd0;
      d_bd_next      = 1'b0;
    end else if (eret && !stall) begin
      f_pc_next      = epc;
      d_pc_next      = epc;
      d_instr_next   = 32'h0;
      d_exccode_next = 5'd0;
      d_bd_next      = 1'b0;
    end else if (!stall) begin
      f_pc_next      = npc;
      d_pc_next      = f_pc_reg;
      d_instr_next   = fetch_word;
      d_exccode_next = fetch_code;
      d_bd_next      = d_is_jump;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_reg      <= PC_RESET;
      d_pc_reg      <= PC_RESET;
      d_instr_reg   <= 32'h0;
      d_exccode_reg <= 5'd0;
      d_bd_reg      <= 1'b0;
    end else begin
      f_pc_reg      <= f_pc_next;
      d_pc_reg      <= d_pc_next;
      d_instr_reg   <= d_instr_next;
      d_exccode_reg <= d_exccode_next;
      d_bd_reg      <= d_bd_next;
    end
  end

  assign f_pc      = f_pc_reg;
  assign d_pc      = d_pc_reg;
  assign d_instr   = d_instr_reg;
  assign d_exccode = d_exccode_reg;
  assign d_bd      = d_bd_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Self-checking bench for fetch_stage. Directed scenarios use literal
//   expected addresses; a randomized run compares every output each cycle
//   against a behavioural model of the PC / F/D update rules.
//   Honours FETCH_ADEL_CHECK_EN the same way as the design.

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic        d_is_jump;
  logic [31:0] im_rdata;
  logic [31:0] f_pc;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic [4:0]  d_exccode;
  logic        d_bd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .npc(npc), .stall(stall), .req(req),
    .eret(eret), .epc(epc), .d_is_jump(d_is_jump), .im_rdata(im_rdata),
    .f_pc(f_pc), .d_pc(d_pc), .d_instr(d_instr), .d_exccode(d_exccode), .d_bd(d_bd)
  );

  // Instruction memory contents: a fixed nonzero function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16] + 16'h1234};
  endfunction

  assign im_rdata = mem_word(f_pc);

  function automatic bit fetch_bad(input logic [31:0] a);
`ifdef FETCH_ADEL_CHECK_EN
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6ffc);
`else
    return 1'b0;
`endif
  endfunction

  // Inputs change only after the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; req = 0; eret = 0; epc = 32'h0; d_is_jump = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; npc = 32'h1234_5678; req = 1; d_is_jump = 1;
    tick(); tick();
    checks++; if (f_pc !== 32'h3000) begin errors++; $display("FAIL reset_f_pc: got %h want %h", f_pc, 32'h3000); end
    checks++; if (d_pc !== 32'h3000) begin errors++; $display("FAIL reset_d_pc: got %h want %h", d_pc, 32'h3000); end
    checks++; if (d_instr !== 32'h0) begin errors++; $display("FAIL reset_d_instr: got %h want 0", d_instr); end
    checks++; if (d_exccode !== 5'd0 || d_bd !== 1'b0) begin errors++; $display("FAIL reset_code_bd: got %0d/%0b want 0/0", d_exccode, d_bd); end
    $display("reset: f_pc=%h d_pc=%h", f_pc, d_pc);
  endtask

  task automatic test_sequential();
    idle_inputs();
    for (int i = 1; i <= 3; i++) begin
      npc = f_pc + 32'd4;
      tick();
      checks++; if (f_pc !== 32'h3000 + 32'(4 * i)) begin errors++; $display("FAIL seq_f_pc[%0d]: got %h want %h", i, f_pc, 32'h3000 + 32'(4 * i)); end
      checks++; if (d_pc !== 32'h3000 + 32'(4 * (i - 1))) begin errors++; $display("FAIL seq_d_pc[%0d]: got %h want %h", i, d_pc, 32'h3000 + 32'(4 * (i - 1))); end
      checks++; if (d_instr !== mem_word(32'h3000 + 32'(4 * (i - 1)))) begin errors++; $display("FAIL seq_d_instr[%0d]: got %h want %h", i, d_instr, mem_word(32'h3000 + 32'(4 * (i - 1)))); end
      $display("seq %0d: f_pc=%h d_pc=%h d_instr=%h", i, f_pc, d_pc, d_instr);
    end
  endtask

  task automatic test_stall();
    idle_inputs();
    npc = 32'h3010; tick();
    stall = 1; npc = 32'h3014;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (f_pc !== 32'h3010) begin errors++; $display("FAIL stall_f_pc[%0d]: got %h want %h", i, f_pc, 32'h3010); end
      checks++; if (d_pc !== 32'h300c) begin errors++; $display("FAIL stall_d_pc[%0d]: got %h want %h", i, d_pc, 32'h300c); end
      checks++; if (d_instr !== mem_word(32'h300c)) begin errors++; $display("FAIL stall_d_instr[%0d]: got %h want %h", i, d_instr, mem_word(32'h300c)); end
      $display("stall %0d: f_pc=%h d_pc=%h", i, f_pc, d_pc);
    end
    stall = 0; tick();
    checks++; if (f_pc !== 32'h3014 || d_pc !== 32'h3010) begin errors++; $display("FAIL stall_release: got f_pc=%h d_pc=%h want 3014/3010", f_pc, d_pc); end
    $display("stall release: f_pc=%h d_pc=%h", f_pc, d_pc);
  endtask

  task automatic test_req_stall();
    idle_inputs();
    npc = 32'h3020; tick();
    req = 1; stall = 1; eret = 1; epc = 32'h3040; d_is_jump = 1; npc = 32'h3024;
    tick();
    checks++; if (f_pc !== 32'h4180) begin errors++; $display("FAIL req_f_pc: got %h want %h", f_pc, 32'h4180); end
    checks++; if (d_pc !== 32'h4180) begin errors++; $display("FAIL req_d_pc: got %h want %h", d_pc, 32'h4180); end
    checks++; if (d_instr !== 32'h0 || d_bd !== 1'b0 || d_exccode !== 5'd0) begin errors++; $display("FAIL req_bubble: got instr=%h bd=%0b code=%0d want 0/0/0", d_instr, d_bd, d_exccode); end
    $display("req: f_pc=%h d_pc=%h d_instr=%h d_bd=%0b", f_pc, d_pc, d_instr, d_bd);
  endtask

  task automatic test_eret();
    idle_inputs();
    eret = 1; epc = 32'h3040; stall = 1; npc = 32'h5000; d_is_jump = 1;
    tick();
    checks++; if (f_pc !== 32'h4180 || d_pc !== 32'h4180) begin errors++; $display("FAIL eret_stalled: got f_pc=%h d_pc=%h want 4180/4180", f_pc, d_pc); end
    stall = 0;
    tick();
    checks++; if (f_pc !== 32'h3040) begin errors++; $display("FAIL eret_f_pc: got %h want %h", f_pc, 32'h3040); end
    checks++; if (d_pc !== 32'h3040 || d_instr !== 32'h0 || d_bd !== 1'b0) begin errors++; $display("FAIL eret_bubble: got d_pc=%h instr=%h bd=%0b want 3040/0/0", d_pc, d_instr, d_bd); end
    $display("eret: f_pc=%h d_pc=%h", f_pc, d_pc);
  endtask

  task automatic test_delay_slot();
    idle_inputs();
    npc = 32'h3050; tick();
    d_is_jump = 1; npc = 32'h3054; tick();
    checks++; if (d_pc !== 32'h3050 || d_bd !== 1'b1) begin errors++; $display("FAIL bd_set: got d_pc=%h bd=%0b want 3050/1", d_pc, d_bd); end
    $display("delay slot: d_pc=%h d_bd=%0b", d_pc, d_bd);
    d_is_jump = 0; npc = 32'h3058; tick();
    checks++; if (d_pc !== 32'h3054 || d_bd !== 1'b0) begin errors++; $display("FAIL bd_clear: got d_pc=%h bd=%0b want 3054/0", d_pc, d_bd); end
    $display("after slot: d_pc=%h d_bd=%0b", d_pc, d_bd);
  endtask

  task automatic test_adel();
    logic [31:0] addrs [5];
    logic [31:0] want_instr;
    logic [4:0]  want_code;
    addrs = '{32'h3002, 32'h7000, 32'h6ffc, 32'h2ffc, 32'h3000};
    idle_inputs();
    npc = addrs[0]; tick();
    for (int i = 0; i < 4; i++) begin
      npc = addrs[i + 1]; tick();
      want_instr = fetch_bad(addrs[i]) ? 32'h0 : mem_word(addrs[i]);
      want_code  = fetch_bad(addrs[i]) ? 5'd4 : 5'd0;
      checks++; if (d_pc !== addrs[i] || d_instr !== want_instr || d_exccode !== want_code) begin
        errors++; $display("FAIL adel[%h]: got d_pc=%h instr=%h code=%0d want %h/%h/%0d", addrs[i], d_pc, d_instr, d_exccode, addrs[i], want_instr, want_code);
      end
      $display("fetch %h: d_instr=%h d_exccode=%0d", addrs[i], d_instr, d_exccode);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    reset = 1; stall = 1; req = 1; npc = 32'h4444;
    tick();
    checks++; if (f_pc !== 32'h3000 || d_pc !== 32'h3000) begin errors++; $display("FAIL midreset: got f_pc=%h d_pc=%h want 3000/3000", f_pc, d_pc); end
    idle_inputs(); npc = 32'h3100;
    tick();
    checks++; if (f_pc !== 32'h3100 || d_pc !== 32'h3000 || d_instr !== mem_word(32'h3000)) begin
      errors++; $display("FAIL postreset: got f_pc=%h d_pc=%h instr=%h want 3100/3000/%h", f_pc, d_pc, d_instr, mem_word(32'h3000));
    end
    $display("mid reset: f_pc=%h d_pc=%h", f_pc, d_pc);
  endtask

  task automatic test_random();
    logic [31:0] m_fpc, m_dpc, m_instr, cand;
    logic [4:0]  m_code;
    logic        m_bd;
    int          bad;
    idle_inputs();
    reset = 1; npc = 32'h0; tick();
    m_fpc = 32'h3000; m_dpc = 32'h3000; m_instr = 0; m_code = 0; m_bd = 0;
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(63) == 0);
      req       = ($urandom_range(15) == 0);
      eret      = ($urandom_range(7) == 0);
      stall     = ($urandom_range(3) == 0);
      d_is_jump = ($urandom_range(3) == 0);
      epc       = 32'h3000 + 32'($urandom_range(32'hfff) * 4);
      case ($urandom_range(9))
        0: cand = 32'h3000 + 32'($urandom_range(32'h3fff));
        1: cand = ($urandom_range(1) == 0) ? 32'h7000 : 32'h2ffc;
        2: cand = $urandom;
        default: cand = (m_fpc >= 32'h6ffc) ? 32'h3000 : m_fpc + 32'd4;
      endcase
      npc = cand;
      // Behavioural model: priority reset > req > eret (unstalled) > stall > load.
      if (reset) begin
        m_fpc = 32'h3000; m_dpc = 32'h3000; m_instr = 0; m_code = 0; m_bd = 0;
      end else if (req) begin
        m_fpc = 32'h4180; m_dpc = 32'h4180; m_instr = 0; m_code = 0; m_bd = 0;
      end else if (eret && !stall) begin
        m_fpc = epc; m_dpc = epc; m_instr = 0; m_code = 0; m_bd = 0;
      end else if (!stall) begin
        bad     = fetch_bad(m_fpc);
        m_dpc   = m_fpc;
        m_instr = bad ? 32'h0 : mem_word(m_fpc);
        m_code  = bad ? 5'd4 : 5'd0;
        m_bd    = d_is_jump;
        m_fpc   = npc;
      end
      tick();
      checks++;
      if (f_pc !== m_fpc || d_pc !== m_dpc || d_instr !== m_instr || d_exccode !== m_code || d_bd !== m_bd) begin
        errors++;
        $display("FAIL rand[%0d]: got f_pc=%h d_pc=%h instr=%h code=%0d bd=%0b want %h/%h/%h/%0d/%0b",
                 n, f_pc, d_pc, d_instr, d_exccode, d_bd, m_fpc, m_dpc, m_instr, m_code, m_bd);
      end
    end
    $display("random: 400 cycles compared");
  endtask

  initial begin
    idle_inputs();
    npc = 32'h0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_req_stall();
    test_eret();
    test_delay_slot();
    test_adel();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage: owns the F-stage program counter and the F/D pipeline register. Each cycle it takes the next PC computed in D (`npc`) and redirects on exception entry or `eret`. It also holds the PC and the F/D register on a stall and flags fetch address errors. It sits between the next-PC logic, the combinational instruction memory and the D stage, and is the sole consumer of `npc`.

## Interface
- `PC_RESET`, 32'h0000_3000: PC value after reset.
- `EXC_ENTRY`, 32'h0000_4180: exception handler address.
- `IM_LO`, 32'h0000_3000: lowest legal fetch address.
- `IM_HI`, 32'h0000_6ffc: highest legal fetch address.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `npc`  in  32  next PC from the next-PC logic.
- `stall`  in  1  hazard stall: hold the PC and F/D register.
- `req`  in  1  exception/interrupt taken this cycle.
- `eret`  in  1  `eret` resolved in D this cycle.
- `epc`  in  32  return address for `eret`.
- `d_is_jump`  in  1  instruction in D is a branch or jump, so the fetched instruction is a delay slot.
- `im_rdata`  in  32  instruction memory data at `f_pc`, combinational.
- `f_pc`  out  32  current fetch address (to IM and next-PC logic).
- `d_pc`  out  32  PC of the instruction in D.
- `d_instr`  out  32  instruction in D.
- `d_exccode`  out  5  fetch exception code carried to D (0 = none, 4 = AdEL).
- `d_bd`  out  1  D instruction is in a branch delay slot.

## Operation
- PC register update, in priority order:
  - `reset`: `f_pc` <= `PC_RESET`.
  - `req`: `f_pc` <= `EXC_ENTRY`.
  - `eret & !stall`: `f_pc` <= `epc`.
  - `stall`: hold.
  - otherwise: `f_pc` <= `npc`.
- F/D register update, in the same priority order:
  - `reset`: `d_pc`=`PC_RESET`, `d_instr`=0, `d_exccode`=0, `d_bd`=0.
  - `req`: flush to a bubble with `d_pc`=`EXC_ENTRY`, `d_instr`=0, `d_exccode`=0, `d_bd`=0.
  - `eret & !stall`: flush to a bubble with `d_pc`=`epc`, other fields 0. `eret` has no delay slot.
  - `stall`: hold all four fields.
  - otherwise: load `d_pc`=`f_pc`, `d_instr`=fetched word, `d_exccode`=fetch code, `d_bd`=`d_is_jump`.
- Fetch check (see Configuration): the fetch is illegal when `f_pc[1:0]`≠0, `f_pc`<`IM_LO`, or `f_pc`>`IM_HI`. An illegal fetch yields fetched word 0 and code 4. A legal fetch yields `im_rdata` and code 0.
- `req` overrides `stall`. `eret` is ignored while `stall`=1 and must be re-presented by D.
- All arithmetic is 32-bit unsigned. Address comparisons are unsigned. This block does no PC+4 addition; `npc` is taken verbatim.

## Timing
- All outputs are registered, with no combinational path from any input to any output.
- `f_pc` changes exactly one cycle after the controlling input is sampled.
- `npc` must be valid and stable at each rising edge while `stall`=0.
- The instruction fetched at `f_pc` appears on `d_instr` at the next edge (1-cycle F→D latency).
- `reset` asserted mid-stream, including during `stall` or `req`, wins at that edge. The first post-reset edge without `reset` loads `d_pc`=`PC_RESET` and `f_pc`=`npc`.
- `req` and `eret` in the same cycle: `req` wins and `epc` is ignored.
- `d_bd` is captured only on a normal load, never on a flush or hold.

## Configuration
- Macro `FETCH_ADEL_CHECK_EN`.
- Defined: the address check above is active and illegal fetches produce bubble instruction 0 with `d_exccode`=4.
- Undefined: no check is done. The fetched word is always `im_rdata`, `d_exccode` is constant 0, and the comparators are removed.

## Test plan
- Reset, then 3 clean cycles with `npc`=`f_pc`+4 -> `f_pc` sequence 0x3000, 0x3004, 0x3008. `d_pc` lags `f_pc` by one cycle. `d_instr` follows `im_rdata`.
- `stall`=1 for 2 cycles at `f_pc`=0x3010 with `npc`=0x3014 -> `f_pc`, `d_pc` and `d_instr` unchanged for both cycles. `f_pc`=0x3014 one cycle after `stall` drops.
- `req`=1 together with `stall`=1 at `f_pc`=0x3020 -> next cycle `f_pc`=0x4180, `d_instr`=0, `d_pc`=0x4180, `d_bd`=0.
- `eret`=1, `epc`=0x3040: with `stall`=0 -> `f_pc`=0x3040 and F/D is a bubble; with `stall`=1 -> no change.
- `d_is_jump`=1 while fetching 0x3050 -> `d_bd`=1 for that instruction. `d_bd`=0 on the following fetch.
- With `FETCH_ADEL_CHECK_EN` and `npc`=0x3002, then 0x7000 -> `d_exccode`=4 and `d_instr`=0 for each. Without the macro -> `d_exccode`=0 and `d_instr`=`im_rdata`.
